vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised raster timing generator: horizontal and vertical pixel counters with sync, blanking and line/frame strobes. It succeeds the single free-running vertical counter and feeds the display controller and pixel pipeline. Counting is gated by a pixel-tick enable and a Start/Stop run-control FSM, so the line and frame geometry is a compile-time choice rather than a hard-coded terminal count.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CNT_W, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- HS_POL, 0, HSync asserted level
- VS_POL, 0, VSync asserted level
- Clk  in  1  system clock
- Reset  in  1  reset Reset, synchronous, active-high; clock Clk
- PixEn  in  1  pixel tick; counters advance only on Clk edges with PixEn=1
- Start  in  1  level/pulse request to begin or resume scanning
- Stop  in  1  request to stop at end of current frame
- cntHorizontal  out  CNT_W  pixel index in line
- cntVertical  out  CNT_W  line index in frame
- HSync  out  1  horizontal sync
- VSync  out  1  vertical sync
- Active  out  1  visible-region flag
- LineEnd  out  1  one-Clk strobe on last pixel of a line
- FrameEnd  out  1  one-Clk strobe on last pixel of a frame
- Running  out  1  high in RUN or DRAIN

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- FSM states IDLE, RUN, DRAIN. Reset -> IDLE.
- IDLE: counters held at 0; HSync=~HS_POL, VSync=~VS_POL, Active=0, strobes 0. Start=1 and Stop=0 -> RUN next Clk.
- RUN: on PixEn, cntHorizontal increments; at H_TOTAL-1 it wraps to 0 and cntVertical increments; cntVertical wraps from V_TOTAL-1 to 0. Stop=1 -> DRAIN.
- DRAIN: counts as RUN; on a FrameEnd tick -> IDLE with counters 0. Start=1 with Stop=0 -> RUN (stop cancelled).
- Stop in RUN on the FrameEnd tick -> IDLE directly.
- Start and Stop both high: Stop wins.
- HSync = HS_POL when H_ACTIVE+H_FP <= cntH < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL. VSync analogous on cntV.
- Active = (cntH < H_ACTIVE) && (cntV < V_ACTIVE) while Running; 0 in IDLE.
- LineEnd = Running && PixEn && cntH==H_TOTAL-1. FrameEnd = LineEnd && cntV==V_TOTAL-1.
- Comparisons are unsigned at CNT_W bits; no intermediate overflow permitted.

## Timing
- Reset: all counters 0, HSync=~HS_POL, VSync=~VS_POL, Active/LineEnd/FrameEnd/Running=0, state IDLE.
- Reset mid-frame: counters return to 0 on the same edge; no partial-frame strobes.
- Start -> Running=1 one Clk later; first counted pixel 0 is presented with counters already 0.
- PixEn=0: all counters and FSM count-dependent transitions freeze; strobes 0.
- Sync/Active/strobe outputs combinational from counters and state (0-cycle latency) unless VGA_OUTREG_EN is defined.

## Configuration
- VGA_OUTREG_EN defined: HSync, VSync, Active, LineEnd and FrameEnd are registered. They lag the counters by exactly one Clk, and their reset values are unchanged.
- VGA_OUTREG_EN undefined: those outputs are combinational, aligned with the counters.

## Test plan
All scenarios use small parameters: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), polarities 0, PixEn=1 unless stated.
- Reset then Start pulse: Running=1 next Clk; cntH steps 0..7 then 0; cntV steps to 1; LineEnd high only at cntH=7.
- Full frame: HSync=0 exactly at cntH 5,6; VSync=0 only at cntV=4; Active high for 12 pixels per frame; FrameEnd once at (7,5); wrap to (0,0).
- PixEn every 3rd Clk: counters advance once per 3 Clk; LineEnd is one Clk wide and coincident with the PixEn tick.
- Stop at cntV=2: DRAIN until (7,5), then IDLE, counters 0, Running=0. A Stop+Start pulse in DRAIN stays DRAIN; Start alone returns to RUN.
- Reset asserted at (3,2) in RUN: next Clk (0,0), IDLE, syncs high, no FrameEnd.
- VGA_OUTREG_EN build: repeat the full-frame scenario; every sync/Active/strobe edge is exactly 1 Clk later than in the unregistered build.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Connects the raster timing generator to its controller and its consumers.
//
// Signals:
//   PixEn          pixel tick; counters advance only when high
//   Start          request to begin or resume scanning
//   Stop           request to stop at the end of the current frame
//   cntHorizontal  pixel index within the line
//   cntVertical    line index within the frame
//   HSync, VSync   sync outputs (asserted level set by HS_POL / VS_POL)
//   Active         visible-region flag
//   LineEnd        one-Clk strobe on the last pixel of a line
//   FrameEnd       one-Clk strobe on the last pixel of a frame
//   Running        generator is scanning (RUN or DRAIN)
//
// Modports:
//   master  controller / consumer side: drives PixEn, Start, Stop
//   slave   timing generator side: drives counters, syncs and strobes
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic             PixEn;
    logic             Start;
    logic             Stop;
    logic [CNT_W-1:0] cntHorizontal;
    logic [CNT_W-1:0] cntVertical;
    logic             HSync;
    logic             VSync;
    logic             Active;
    logic             LineEnd;
    logic             FrameEnd;
    logic             Running;

    modport master (
        output PixEn, Start, Stop,
        input  cntHorizontal, cntVertical, HSync, VSync,
               Active, LineEnd, FrameEnd, Running
    );

    modport slave (
        input  PixEn, Start, Stop,
        output cntHorizontal, cntVertical, HSync, VSync,
               Active, LineEnd, FrameEnd, Running
    );
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator. Horizontal and vertical pixel counters
// advance on PixEn ticks while a Start/Stop run-control FSM is in RUN or DRAIN.
// Sync, blanking and line/frame strobes are decoded from the counters.
//
// Ports:
//   Clk    system clock
//   Reset  synchronous, active-high reset
//   tmg    vga_timing_gen_if.slave (controls in, counters/syncs/strobes out)
//
// Build option:
//   VGA_OUTREG_EN  when defined, HSync, VSync, Active, LineEnd and FrameEnd
//                  are registered and lag the counters by one Clk. When
//                  undefined they are combinational and aligned with the
//                  counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | counters held at 0, outputs inactive, waiting for Start
// ST_RUN   | scanning; Stop moves to DRAIN (or IDLE on the FrameEnd tick)
// ST_DRAIN | scanning until FrameEnd, then IDLE; Start alone resumes RUN
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CNT_W    = 11,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic                Clk,
    input  logic                Reset,
    vga_timing_gen_if.slave     tmg
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows are expressed as inclusive [first, last] so that no bound
    // ever needs to represent H_TOTAL itself at CNT_W bits.
    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_END    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_h_q;
    logic [CNT_W-1:0] cnt_v_q;

    logic running;
    logic h_in_sync;
    logic v_in_sync;
    logic hs_d;
    logic vs_d;
    logic act_d;
    logic le_d;
    logic fe_d;
    logic resume;

    always_comb begin
        running   = (state_q != ST_IDLE);
        h_in_sync = (cnt_h_q >= H_SYNC_FIRST) && (cnt_h_q <= H_SYNC_LAST);
        v_in_sync = (cnt_v_q >= V_SYNC_FIRST) && (cnt_v_q <= V_SYNC_LAST);
        hs_d      = (running && h_in_sync) ? HS_POL : ~HS_POL;
        vs_d      = (running && v_in_sync) ? VS_POL : ~VS_POL;
        act_d     = running && (cnt_h_q < H_ACT_END) && (cnt_v_q < V_ACT_END);
        le_d      = running && tmg.PixEn && (cnt_h_q == H_LAST);
        fe_d      = le_d && (cnt_v_q == V_LAST);
        // Stop always dominates a simultaneous Start.
        resume    = tmg.Start && !tmg.Stop;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_h_q <= '0;
            cnt_v_q <= '0;
        end else begin
            if (running && tmg.PixEn) begin
                if (cnt_h_q == H_LAST) begin
                    cnt_h_q <= '0;
                    cnt_v_q <= (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 1'b1;
                end else begin
                    cnt_h_q <= cnt_h_q + 1'b1;
                end
            end

            // Leaving scan on the FrameEnd tick needs no explicit counter
            // clear: the wrap above already lands on (0,0).
            unique case (state_q)
                ST_IDLE: begin
                    cnt_h_q <= '0;
                    cnt_v_q <= '0;
                    if (resume) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (tmg.Stop) state_q <= fe_d ? ST_IDLE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (resume)    state_q <= ST_RUN;
                    else if (fe_d) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tmg.cntHorizontal = cnt_h_q;
    assign tmg.cntVertical   = cnt_v_q;
    assign tmg.Running       = running;

`ifdef VGA_OUTREG_EN
    logic hs_q;
    logic vs_q;
    logic act_q;
    logic le_q;
    logic fe_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            act_q <= 1'b0;
            le_q  <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            act_q <= act_d;
            le_q  <= le_d;
            fe_q  <= fe_d;
        end
    end

    assign tmg.HSync    = hs_q;
    assign tmg.VSync    = vs_q;
    assign tmg.Active   = act_q;
    assign tmg.LineEnd  = le_q;
    assign tmg.FrameEnd = fe_q;
`else
    assign tmg.HSync    = hs_d;
    assign tmg.VSync    = vs_d;
    assign tmg.Active   = act_d;
    assign tmg.LineEnd  = le_d;
    assign tmg.FrameEnd = fe_d;
`endif

endmodule
